// File: rtl/controle_medicao_periodica.sv
// Periodic measurement controller for an HC-SR04 interface: issues a request every
// PERIODO cycles, waits for the reply with a timeout, and filters samples with a 4-tap moving average.
module controle_medicao_periodica #(
    parameter int W       = 12,
    parameter int PERIODO = 50000000,
    parameter int TIMEOUT = 2500000
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         ligar,
    input  logic         pronto_medida,
    input  logic [W-1:0] distancia,
    output logic         medir,
    output logic [W-1:0] distancia_media,
    output logic         valido,
    output logic         erro,
    output logic [3:0]   conta_erros,
    output logic [3:0]   db_estado
);

    localparam int MAXC = (PERIODO > TIMEOUT) ? PERIODO : TIMEOUT;
    localparam int CW   = (MAXC > 2) ? $clog2(MAXC) : 1;
    localparam logic [CW-1:0] FIM_PERIODO = CW'(PERIODO - 1);
    localparam logic [CW-1:0] FIM_TIMEOUT = CW'(TIMEOUT - 1);

    // Encodings double as the debug display codes.
    typedef enum logic [3:0] {
        INICIAL  = 4'b0000,
        ESPERA   = 4'b0001,
        SOLICITA = 4'b0010,
        AGUARDA  = 4'b0011,
        ACUMULA  = 4'b0100,
        CALCULA  = 4'b0101,
        FALHA    = 4'b1110,
        FINAL    = 4'b1111
    } estado_t;

    estado_t estado_q, estado_d;

    logic [CW-1:0] conta_q, conta_d;
    logic [W-1:0]  amostra_q, amostra_d;
    logic [W-1:0]  w0_q, w0_d;
    logic [W-1:0]  w1_q, w1_d;
    logic [W-1:0]  w2_q, w2_d;
    logic [W-1:0]  w3_q, w3_d;
    logic [W+1:0]  soma_q, soma_d;
    logic [2:0]    n_amostras_q, n_amostras_d;
    logic [W-1:0]  media_q, media_d;
    logic          erro_q, erro_d;
    logic [3:0]    conta_erros_q, conta_erros_d;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q <= INICIAL;
        end else begin
            estado_q <= estado_d;
        end
    end

    // ligar is only looked at while idle or waiting, so an in-flight measurement always completes.
    always_comb begin
        estado_d = estado_q;
        case (estado_q)
            INICIAL: begin
                if (ligar) estado_d = ESPERA;
            end
            ESPERA: begin
                if (!ligar) begin
                    estado_d = INICIAL;
                end else if (conta_q == FIM_PERIODO) begin
                    estado_d = SOLICITA;
                end
            end
            SOLICITA: estado_d = AGUARDA;
            AGUARDA: begin
                if (pronto_medida) begin
                    estado_d = ACUMULA;
                end else if (conta_q == FIM_TIMEOUT) begin
                    estado_d = FALHA;
                end
            end
            ACUMULA: estado_d = CALCULA;
            CALCULA: estado_d = FINAL;
            FINAL:   estado_d = ESPERA;
            FALHA:   estado_d = ESPERA;
            default: estado_d = INICIAL;
        endcase
    end

    always_comb begin
        medir     = 1'b0;
        valido    = 1'b0;
        db_estado = 4'b1110;
        case (estado_q)
            INICIAL:  db_estado = 4'b0000;
            ESPERA:   db_estado = 4'b0001;
            SOLICITA: begin
                db_estado = 4'b0010;
                medir     = 1'b1;
            end
            AGUARDA:  db_estado = 4'b0011;
            ACUMULA:  db_estado = 4'b0100;
            CALCULA:  db_estado = 4'b0101;
            FINAL: begin
                db_estado = 4'b1111;
                valido    = (n_amostras_q == 3'd4);
            end
            FALHA:    db_estado = 4'b1110;
            default:  db_estado = 4'b1110;
        endcase
    end

    // Shared counter: period count in ESPERA, timeout count in AGUARDA, zero elsewhere,
    // so it is cleared on every entry to either state.
    always_comb begin
        conta_d       = '0;
        amostra_d     = amostra_q;
        w0_d          = w0_q;
        w1_d          = w1_q;
        w2_d          = w2_q;
        w3_d          = w3_q;
        soma_d        = soma_q;
        n_amostras_d  = n_amostras_q;
        media_d       = media_q;
        erro_d        = erro_q;
        conta_erros_d = conta_erros_q;
        case (estado_q)
            ESPERA: conta_d = conta_q + 1'b1;
            AGUARDA: begin
                conta_d = conta_q + 1'b1;
                if (pronto_medida) amostra_d = distancia;
            end
            ACUMULA: begin
                w0_d   = amostra_q;
                w1_d   = w0_q;
                w2_d   = w1_q;
                w3_d   = w2_q;
                // Running sum of the window: add the newcomer, drop the oldest.
                soma_d = soma_q + {2'b00, amostra_q} - {2'b00, w3_q};
                if (n_amostras_q != 3'd4) n_amostras_d = n_amostras_q + 3'd1;
            end
            CALCULA: begin
                if (n_amostras_q == 3'd4) media_d = soma_q[W+1:2];
                erro_d = 1'b0;
            end
            FALHA: begin
                erro_d = 1'b1;
                if (conta_erros_q != 4'hF) conta_erros_d = conta_erros_q + 4'd1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            conta_q       <= '0;
            amostra_q     <= '0;
            w0_q          <= '0;
            w1_q          <= '0;
            w2_q          <= '0;
            w3_q          <= '0;
            soma_q        <= '0;
            n_amostras_q  <= '0;
            media_q       <= '0;
            erro_q        <= 1'b0;
            conta_erros_q <= '0;
        end else begin
            conta_q       <= conta_d;
            amostra_q     <= amostra_d;
            w0_q          <= w0_d;
            w1_q          <= w1_d;
            w2_q          <= w2_d;
            w3_q          <= w3_d;
            soma_q        <= soma_d;
            n_amostras_q  <= n_amostras_d;
            media_q       <= media_d;
            erro_q        <= erro_d;
            conta_erros_q <= conta_erros_d;
        end
    end

    assign distancia_media = media_q;
    assign erro            = erro_q;
    assign conta_erros     = conta_erros_q;

endmodule

// File: tb/tb_controle_medicao_periodica.sv
// Randomized bench for controle_medicao_periodica: a sensor responder drives replies and
// timeouts, and a window-of-last-4-samples model predicts every filtered output.
module tb_controle_medicao_periodica;

    localparam int W       = 12;
    localparam int PERIODO = 10;
    localparam int TIMEOUT = 20;
    localparam int MAXV    = (1 << W) - 1;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         ligar = 1'b0;
    logic         pronto_medida = 1'b0;
    logic [W-1:0] distancia = '0;
    logic         medir;
    logic [W-1:0] distancia_media;
    logic         valido;
    logic         erro;
    logic [3:0]   conta_erros;
    logic [3:0]   db_estado;

    controle_medicao_periodica #(
        .W       (W),
        .PERIODO (PERIODO),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .ligar           (ligar),
        .pronto_medida   (pronto_medida),
        .distancia       (distancia),
        .medir           (medir),
        .distancia_media (distancia_media),
        .valido          (valido),
        .erro            (erro),
        .conta_erros     (conta_erros),
        .db_estado       (db_estado)
    );

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no end expected end of stimulus");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard state ----------------
    int n_cmp = 0;
    int n_err = 0;
    int n_valido = 0;
    int n_medir = 0;
    int last_medir_cyc = 0;
    int exp_gap = -1;

    int mdl_win[$];
    int mdl_media = 0;
    int mdl_erro = 0;
    int mdl_cerr = 0;
    logic [W-1:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Every valido pulse must match the next queued average.
    always @(negedge clock) begin
        logic [W-1:0] e;
        if (reset && valido) begin
            n_valido <= n_valido + 1;
            if (exp_q.size() == 0) begin
                check_eq("valido_inesperado", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check_eq("media_no_valido", distancia_media, e);
            end
        end
        if (reset && medir) n_medir <= n_medir + 1;
    end

    // ---------------- reference model ----------------
    task automatic mdl_clear();
        mdl_win.delete();
        exp_q.delete();
        mdl_media = 0;
        mdl_erro  = 0;
        mdl_cerr  = 0;
        exp_gap   = -1;
    endtask

    function automatic int mdl_push(input int v);
        int soma;
        mdl_win.push_front(v);
        if (mdl_win.size() > 4) void'(mdl_win.pop_back());
        mdl_erro = 0;
        if (mdl_win.size() == 4) begin
            soma = 0;
            foreach (mdl_win[i]) soma += mdl_win[i];
            mdl_media = soma / 4;
            return 1;
        end
        return 0;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic wait_medir(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < PERIODO + TIMEOUT + 20; i++) begin
            @(negedge clock);
            if (medir) begin
                ok = 1'b1;
                break;
            end
            distancia = W'($urandom_range(0, MAXV));
        end
        check_eq("medir_visto", {31'd0, ok}, 32'd1);
        if (ok) begin
            check_eq("estado_solicita", db_estado, 32'd2);
            if (exp_gap >= 0) check_eq("espacamento_medir", cyc - last_medir_cyc, exp_gap);
            last_medir_cyc = cyc;
        end
    endtask

    // Answer the next request d cycles into AGUARDA (d=1..TIMEOUT).
    task automatic medicao(input int d, input int v, input bit drop);
        bit ok;
        int v0;
        int full;
        wait_medir(ok);
        if (!ok) return;
        @(negedge clock);
        check_eq("medir_1ciclo", medir, 32'd0);
        check_eq("estado_aguarda", db_estado, 32'd3);
        if (drop) ligar = 1'b0;
        repeat (d - 1) begin
            @(negedge clock);
            distancia = W'($urandom_range(0, MAXV));
        end
        pronto_medida = 1'b1;
        distancia     = W'(v);
        full = mdl_push(v);
        if (full != 0) exp_q.push_back(W'(mdl_media));
        exp_gap = PERIODO + 1 + d + 3;
        v0 = n_valido;
        @(negedge clock);
        pronto_medida = 1'b0;
        distancia     = W'($urandom_range(0, MAXV));
        repeat (3) @(negedge clock);
        check_eq("contagem_valido", n_valido - v0, full);
        check_eq("erro_apos_amostra", erro, mdl_erro);
        check_eq("conta_erros_amostra", conta_erros, mdl_cerr);
        check_eq("media_apos_amostra", distancia_media, mdl_media);
    endtask

    task automatic falha();
        bit ok;
        wait_medir(ok);
        if (!ok) return;
        @(negedge clock);
        check_eq("medir_1ciclo_f", medir, 32'd0);
        repeat (TIMEOUT - 1) @(negedge clock);
        check_eq("ainda_aguarda", db_estado, 32'd3);
        check_eq("erro_antes_timeout", erro, mdl_erro);
        @(negedge clock);
        check_eq("estado_falha", db_estado, 32'd14);
        @(negedge clock);
        mdl_erro = 1;
        if (mdl_cerr < 15) mdl_cerr++;
        exp_gap = PERIODO + 1 + TIMEOUT + 1;
        check_eq("erro_apos_timeout", erro, mdl_erro);
        check_eq("conta_erros_timeout", conta_erros, mdl_cerr);
        check_eq("media_mantida_timeout", distancia_media, mdl_media);
        check_eq("estado_espera_pos_falha", db_estado, 32'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit ok;
        int m0;
        #2;
        check_eq("rst_medir", medir, 32'd0);
        check_eq("rst_valido", valido, 32'd0);
        check_eq("rst_erro", erro, 32'd0);
        check_eq("rst_conta_erros", conta_erros, 32'd0);
        check_eq("rst_media", distancia_media, 32'd0);
        check_eq("rst_estado", db_estado, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        repeat (5) @(negedge clock);
        check_eq("ocioso_sem_ligar", db_estado, 32'd0);
        check_eq("ocioso_sem_medir", n_medir, 32'd0);

        ligar = 1'b1;
        medicao(5, 100, 1'b0);
        medicao(5, 200, 1'b0);
        medicao(5, 300, 1'b0);
        medicao(5, 400, 1'b0);
        medicao(5, 501, 1'b0);

        falha();
        medicao(TIMEOUT, $urandom_range(0, MAXV), 1'b0);
        repeat (16) falha();
        medicao($urandom_range(1, TIMEOUT), $urandom_range(0, MAXV), 1'b0);

        for (int i = 0; i < 20; i++) begin
            if ($urandom_range(0, 4) == 0) falha();
            else medicao($urandom_range(1, TIMEOUT), $urandom_range(0, MAXV), 1'b0);
        end
        medicao(1, MAXV, 1'b0);

        // Asynchronous reset in the middle of AGUARDA.
        wait_medir(ok);
        repeat (3) @(negedge clock);
        reset = 1'b0;
        #1;
        check_eq("rst_meio_medir", medir, 32'd0);
        check_eq("rst_meio_valido", valido, 32'd0);
        check_eq("rst_meio_erro", erro, 32'd0);
        check_eq("rst_meio_conta_erros", conta_erros, 32'd0);
        check_eq("rst_meio_media", distancia_media, 32'd0);
        check_eq("rst_meio_estado", db_estado, 32'd0);
        mdl_clear();
        @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            medicao($urandom_range(1, TIMEOUT), $urandom_range(0, MAXV), 1'b0);
        end

        // Drop ligar mid-measurement; then a stray reply while idle.
        medicao($urandom_range(2, 8), $urandom_range(0, MAXV), 1'b1);
        repeat (2) @(negedge clock);
        check_eq("volta_inicial", db_estado, 32'd0);
        m0 = n_medir;
        repeat (5) @(negedge clock);
        pronto_medida = 1'b1;
        distancia     = W'(77);
        @(negedge clock);
        pronto_medida = 1'b0;
        repeat (40) @(negedge clock);
        check_eq("sem_medir_desligado", n_medir - m0, 32'd0);
        check_eq("pronto_ignorado_estado", db_estado, 32'd0);
        check_eq("pronto_ignorado_media", distancia_media, mdl_media);

        ligar   = 1'b1;
        exp_gap = -1;
        medicao(3, $urandom_range(0, MAXV), 1'b0);
        medicao(TIMEOUT, $urandom_range(0, MAXV), 1'b0);

        repeat (5) @(negedge clock);
        check_eq("fila_esperada_vazia", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
